mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_port.sv | 34 +++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_LOCK_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/mem_arb_port.sv
// Per-port read return: rvalid one cycle after a granted read, rdata held between pulses.
module mem_arb_port
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_issue,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic              vld_p1;
    logic [DATA_W-1:0] rdata_p1;

    // Stage p1: memory returns data in the cycle after the read command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= rd_issue;
            if (vld_p1) begin
                rdata_p1 <= rd_data;
            end
        end
    end

    assign rvalid = vld_p1;
    assign rdata  = vld_p1 ? rd_data : rdata_p1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with per-requester lock and a bounded hold counter.
// Define MEM_ARB_RR_EN for round-robin tie-breaking in IDLE; default is fixed port-0 priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_lock,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_lock,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    arb_state_t        state;
    logic [CNT_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]  cnt_sum;
    logic              force_vld;
    port_idx_t         force_port;
    port_idx_t         tie_win;
    port_idx_t         win;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic              win_lock;
    logic              win_wr;
    logic              lose_req;
    logic              own_req;
    logic              own_lock;
    logic              other_req;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] win_wdata;
    logic [DATA_W-1:0] wdata_q;

    // A forced release hands the very next IDLE tie to the port that was held off.
`ifdef MEM_ARB_RR_EN
    port_idx_t last_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= PORT1;
        end else if (gnt_any) begin
            last_gnt <= win;
        end
    end

    assign tie_win = force_vld ? force_port : ~last_gnt;
`else
    assign tie_win = force_vld ? force_port : PORT0;
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            case (state)
                OWN0:    gnt0 = p0_req;
                OWN1:    gnt1 = p1_req;
                default: begin
                    if (p0_req && p1_req) begin
                        gnt0 = (tie_win == PORT0);
                        gnt1 = (tie_win == PORT1);
                    end else begin
                        gnt0 = p0_req;
                        gnt1 = p1_req;
                    end
                end
            endcase
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign gnt_any   = gnt0 | gnt1;
    assign win       = gnt1 ? PORT1 : PORT0;
    assign win_lock  = gnt1 ? p1_lock : p0_lock;
    assign win_wr    = gnt1 ? p1_wr : p0_wr;
    assign win_addr  = gnt1 ? p1_addr : p0_addr;
    assign win_wdata = gnt1 ? p1_wdata : p0_wdata;
    assign lose_req  = gnt1 ? p0_req : p1_req;
    assign own_req   = (state == OWN1) ? p1_req : p0_req;
    assign own_lock  = (state == OWN1) ? p1_lock : p0_lock;
    assign other_req = (state == OWN1) ? p0_req : p1_req;

    // The grant that enters a lock counts as the first locked grant.
    assign cnt_sum = (state == IDLE) ? CNT_W'(1) : sat_inc(hold_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            force_vld  <= 1'b0;
            force_port <= PORT0;
        end else begin
            force_vld <= 1'b0;
            case (state)
                OWN0, OWN1: begin
                    if (!own_req || !own_lock) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (cnt_sum == CNT_MAX && other_req) begin
                        state      <= IDLE;
                        hold_cnt   <= '0;
                        force_vld  <= 1'b1;
                        force_port <= (state == OWN0) ? PORT1 : PORT0;
                    end else begin
                        hold_cnt <= cnt_sum;
                    end
                end
                default: begin
                    if (gnt_any && win_lock) begin
                        if (cnt_sum == CNT_MAX && lose_req) begin
                            force_vld  <= 1'b1;
                            force_port <= ~win;
                        end else begin
                            state    <= (win == PORT1) ? OWN1 : OWN0;
                            hold_cnt <= cnt_sum;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (gnt_any) begin
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
        end
    end

    assign mem_addr = gnt_any ? win_addr : addr_q;
    assign wr_data  = gnt_any ? win_wdata : wdata_q;
    assign mem_wr   = gnt_any & win_wr;

    mem_arb_port #(.DATA_W(DATA_W)) u_port0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_issue (gnt0 & ~p0_wr),
        .rd_data  (rd_data),
        .rvalid   (p0_rvalid),
        .rdata    (p0_rdata)
    );

    mem_arb_port #(.DATA_W(DATA_W)) u_port1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_issue (gnt1 & ~p1_wr),
        .rd_data  (rd_data),
        .rvalid   (p1_rvalid),
        .rdata    (p1_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 16;
    localparam int LOCK_MAX = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              p0_req, p0_lock, p0_wr;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt, p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p1_req, p1_lock, p1_wr;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_wr(p0_wr), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_wr(p1_wr), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .wr_data(wr_data), .rd_data(rd_data)
    );

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
            mem[10'h100] <= 16'hBEEF;
            mem_loaded   <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr] <= wr_data;
        end
        rd_data <= mem[mem_addr];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_lock = 1'b0; p0_wr = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_lock = 1'b0; p1_wr = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        p0_req  = 1'b1;
        p0_addr = 10'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
                fails++;
                $display("FAIL reset_gnt cyc%0d: gnt=%b%b, expected 00", i, p0_gnt, p1_gnt);
            end
            tests++;
            if (mem_wr !== 1'b0 || mem_addr !== 10'h000 || wr_data !== 16'h0000) begin
                fails++;
                $display("FAIL reset_mem cyc%0d: wr=%b addr=%h wdata=%h, expected 0 000 0000",
                         i, mem_wr, mem_addr, wr_data);
            end
            tests++;
            if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p0_rdata !== 16'h0 || p1_rdata !== 16'h0) begin
                fails++;
                $display("FAIL reset_ret cyc%0d: rvalid=%b%b rdata=%h/%h, expected 00 0000/0000",
                         i, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
            end
        end
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            fails++;
            $display("FAIL first_gnt: gnt=%b%b, expected 10", p0_gnt, p1_gnt);
        end
        tests++;
        if (mem_addr !== 10'h100 || mem_wr !== 1'b0) begin
            fails++;
            $display("FAIL first_cmd: addr=%h wr=%b, expected 100 0", mem_addr, mem_wr);
        end
        cyc();
        p0_req = 1'b0;
        @(negedge clk);
        tests++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 16'hBEEF) begin
            fails++;
            $display("FAIL first_ret: rvalid=%b rdata=%h, expected 1 beef", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_read();
        cyc();
        idle_inputs();
        p0_req  = 1'b1;
        p0_addr = 10'h100;
        @(negedge clk);
        tests++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || mem_addr !== 10'h100 || mem_wr !== 1'b0) begin
            fails++;
            $display("FAIL read_gnt: gnt=%b%b addr=%h wr=%b, expected 10 100 0",
                     p0_gnt, p1_gnt, mem_addr, mem_wr);
        end
        cyc();
        p0_req  = 1'b0;
        p0_addr = 10'h3AA;
        @(negedge clk);
        tests++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 16'hBEEF || p1_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL read_ret: p0_rvalid=%b p0_rdata=%h p1_rvalid=%b, expected 1 beef 0",
                     p0_rvalid, p0_rdata, p1_rvalid);
        end
        tests++;
        if (p0_gnt !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 10'h100) begin
            fails++;
            $display("FAIL read_nogrant_hold: gnt=%b wr=%b addr=%h, expected 0 0 100",
                     p0_gnt, mem_wr, mem_addr);
        end
        cyc();
        @(negedge clk);
        tests++;
        if (p0_rvalid !== 1'b0 || p0_rdata !== 16'hBEEF) begin
            fails++;
            $display("FAIL read_rdata_hold: rvalid=%b rdata=%h, expected 0 beef", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_write();
        cyc();
        idle_inputs();
        p1_req   = 1'b1;
        p1_wr    = 1'b1;
        p1_addr  = 10'h001;
        p1_wdata = 16'h1234;
        @(negedge clk);
        tests++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || mem_wr !== 1'b1 ||
            mem_addr !== 10'h001 || wr_data !== 16'h1234) begin
            fails++;
            $display("FAIL write_cmd: gnt=%b%b wr=%b addr=%h wdata=%h, expected 01 1 001 1234",
                     p0_gnt, p1_gnt, mem_wr, mem_addr, wr_data);
        end
        cyc();
        p1_req = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_wr !== 1'b0 || p1_rvalid !== 1'b0 || mem[10'h001] !== 16'h1234) begin
            fails++;
            $display("FAIL write_after: wr=%b p1_rvalid=%b mem=%h, expected 0 0 1234",
                     mem_wr, p1_rvalid, mem[10'h001]);
        end
    endtask

    task automatic test_priority();
        logic e0, e1, pv0, pv1;
        pv0 = 1'b0;
        pv1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            idle_inputs();
            p0_req  = 1'b1;
            p0_addr = 10'h010;
            p1_req  = 1'b1;
            p1_addr = 10'h020;
`ifdef MEM_ARB_RR_EN
            e0 = (i % 2 == 0);
`else
            e0 = 1'b1;
`endif
            e1 = ~e0;
            @(negedge clk);
            tests++;
            if (p0_gnt !== e0 || p1_gnt !== e1) begin
                fails++;
                $display("FAIL prio_gnt cyc%0d: gnt=%b%b, expected %b%b", i, p0_gnt, p1_gnt, e0, e1);
            end
            tests++;
            if (p0_rvalid !== pv0 || p1_rvalid !== pv1) begin
                fails++;
                $display("FAIL prio_rvalid cyc%0d: rvalid=%b%b, expected %b%b",
                         i, p0_rvalid, p1_rvalid, pv0, pv1);
            end
            tests++;
            if (mem_addr !== (e0 ? 10'h010 : 10'h020)) begin
                fails++;
                $display("FAIL prio_addr cyc%0d: addr=%h, expected %h", i, mem_addr, e0 ? 10'h010 : 10'h020);
            end
            pv0 = e0;
            pv1 = e1;
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        tests++;
        if (p0_rvalid !== pv0 || p1_rvalid !== pv1) begin
            fails++;
            $display("FAIL prio_last_rvalid: rvalid=%b%b, expected %b%b", p0_rvalid, p1_rvalid, pv0, pv1);
        end
    endtask

    task automatic test_lock_release();
        int  d;
        logic e1;
        for (int c = 0; c <= 10; c++) begin
            cyc();
            idle_inputs();
            p0_req   = (c >= 1 && c <= 8);
            p0_addr  = 10'h100;
            d        = (c <= 8) ? c + 1 : c;
            p1_req   = 1'b1;
            p1_lock  = 1'b1;
            p1_wr    = 1'b1;
            p1_addr  = 10'(10'h1FF + d);
            p1_wdata = 16'(d);
            e1       = (c != 8);
            @(negedge clk);
            tests++;
            if (p1_gnt !== e1 || p0_gnt !== ~e1) begin
                fails++;
                $display("FAIL lock_gnt cyc%0d: gnt=%b%b, expected %b%b", c, p0_gnt, p1_gnt, ~e1, e1);
            end
            if (e1) begin
                tests++;
                if (mem_wr !== 1'b1 || wr_data !== 16'(d) || mem_addr !== 10'(10'h1FF + d)) begin
                    fails++;
                    $display("FAIL lock_cmd cyc%0d: wr=%b addr=%h wdata=%h, expected 1 %h %h",
                             c, mem_wr, mem_addr, wr_data, 10'(10'h1FF + d), 16'(d));
                end
            end
            if (c == 9) begin
                tests++;
                if (p0_rvalid !== 1'b1 || p0_rdata !== 16'hBEEF || p1_rvalid !== 1'b0) begin
                    fails++;
                    $display("FAIL lock_p0_ret: rvalid=%b%b rdata=%h, expected 10 beef",
                             p0_rvalid, p1_rvalid, p0_rdata);
                end
            end
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        tests++;
        if (mem[10'h207] !== 16'h0008 || mem[10'h208] !== 16'h0009 || mem[10'h209] !== 16'h000A) begin
            fails++;
            $display("FAIL lock_mem: mem[207..209]=%h %h %h, expected 0008 0009 000a",
                     mem[10'h207], mem[10'h208], mem[10'h209]);
        end
    endtask

    task automatic test_lock_saturate();
        logic e1;
        for (int c = 0; c <= 11; c++) begin
            cyc();
            idle_inputs();
            p0_req   = 1'b1;
            p0_lock  = 1'b1;
            p0_wr    = 1'b1;
            p0_addr  = 10'(10'h300 + ((c < 10) ? c : 10));
            p0_wdata = 16'hA000;
            p1_req   = (c >= 10);
            p1_wr    = 1'b1;
            p1_addr  = 10'h3FF;
            p1_wdata = 16'h5555;
            e1       = (c == 11);
            @(negedge clk);
            tests++;
            if (p1_gnt !== e1 || p0_gnt !== ~e1) begin
                fails++;
                $display("FAIL sat_gnt cyc%0d: gnt=%b%b, expected %b%b", c, p0_gnt, p1_gnt, ~e1, e1);
            end
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        tests++;
        if (mem[10'h3FF] !== 16'h5555) begin
            fails++;
            $display("FAIL sat_mem: mem[3ff]=%h, expected 5555", mem[10'h3FF]);
        end
    endtask

    task automatic test_reset_inflight();
        cyc();
        idle_inputs();
        p0_req  = 1'b1;
        p0_addr = 10'h100;
        @(negedge clk);
        tests++;
        if (p0_gnt !== 1'b1) begin
            fails++;
            $display("FAIL inflight_gnt: p0_gnt=%b, expected 1", p0_gnt);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (p0_gnt !== 1'b0 || mem_addr !== 10'h000) begin
            fails++;
            $display("FAIL inflight_rst_async: gnt=%b addr=%h, expected 0 000", p0_gnt, mem_addr);
        end
        cyc();
        p0_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (p0_rvalid !== 1'b0 || p0_rdata !== 16'h0000) begin
                fails++;
                $display("FAIL inflight_in_rst cyc%0d: rvalid=%b rdata=%h, expected 0 0000",
                         i, p0_rvalid, p0_rdata);
            end
        end
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
                fails++;
                $display("FAIL inflight_after cyc%0d: rvalid=%b%b, expected 00", i, p0_rvalid, p1_rvalid);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_read();
        test_write();
        test_priority();
        test_lock_release();
        test_lock_saturate();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
